// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between two requesters, each with a one-entry result buffer.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority with a requester-1 starvation guard; default is round-robin.
module alu_arbiter #(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r0_valid,
  input  logic [31:0] r0_a,
  input  logic [31:0] r0_b,
  input  logic [3:0]  r0_aluc,
  output logic        r0_ready,
  output logic        resp0_valid,
  output logic [31:0] resp0_r,
  output logic [3:0]  resp0_flags,
  input  logic        resp0_ack,
  input  logic        r1_valid,
  input  logic [31:0] r1_a,
  input  logic [31:0] r1_b,
  input  logic [3:0]  r1_aluc,
  output logic        r1_ready,
  output logic        resp1_valid,
  output logic [31:0] resp1_r,
  output logic [3:0]  resp1_flags,
  input  logic        resp1_ack,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_aluc,
  input  logic [31:0] alu_r,
  input  logic        alu_zero,
  input  logic        alu_carry,
  input  logic        alu_negative,
  input  logic        alu_overflow
);

  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_starve_max_check
    $error("alu_arbiter: STARVE_MAX must be in 1..15");
  end

  // Handshake: an operation transfers in a cycle where rN_valid && rN_ready; rN_ready
  // is only offered when the buffer is empty or is being acked in that same cycle.
  logic elig0, elig1;
  logic gnt0, gnt1;
  logic [3:0] alu_flags;

  assign elig0 = r0_valid & (~resp0_valid | resp0_ack);
  assign elig1 = r1_valid & (~resp1_valid | resp1_ack);
  assign alu_flags = {alu_zero, alu_carry, alu_negative, alu_overflow};

`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  logic [3:0] starve_q;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      gnt1 = elig1 & (~elig0 | (starve_q == STARVE_LIM));
      gnt0 = elig0 & ~gnt1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= 4'd0;
    end else if (!r1_valid || gnt1) begin
      starve_q <= 4'd0;
    end else if (elig1 && gnt0) begin
      starve_q <= starve_q + 4'd1;
    end
  end
`else
  // last_q names the requester granted most recently; reset to 1 so requester 0 wins first.
  logic last_q;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      gnt1 = elig1 & (~elig0 | ~last_q);
      gnt0 = elig0 & ~gnt1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (gnt0 || gnt1) begin
      last_q <= gnt1;
    end
  end
`endif

  assign r0_ready = gnt0;
  assign r1_ready = gnt1;

  always_comb begin
    alu_a    = 32'd0;
    alu_b    = 32'd0;
    alu_aluc = 4'd0;
    if (gnt0) begin
      alu_a    = r0_a;
      alu_b    = r0_b;
      alu_aluc = r0_aluc;
    end else if (gnt1) begin
      alu_a    = r1_a;
      alu_b    = r1_b;
      alu_aluc = r1_aluc;
    end
  end

  // A grant on the same edge as an ack refills the buffer, so capture wins over clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp0_valid <= 1'b0;
      resp0_r     <= 32'd0;
      resp0_flags <= 4'd0;
    end else if (gnt0) begin
      resp0_valid <= 1'b1;
      resp0_r     <= alu_r;
      resp0_flags <= alu_flags;
    end else if (resp0_ack) begin
      resp0_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp1_valid <= 1'b0;
      resp1_r     <= 32'd0;
      resp1_flags <= 4'd0;
    end else if (gnt1) begin
      resp1_valid <= 1'b1;
      resp1_r     <= alu_r;
      resp1_flags <= alu_flags;
    end else if (resp1_ack) begin
      resp1_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: random and directed traffic against a transaction-level arbitration model,
// with a behavioural ALU on the shared port and per-requester expected-result queues.
module tb_alu_arbiter;

  localparam int STARVE = 3;

  logic        clk, rst;
  logic        r0_valid, r1_valid, r0_ready, r1_ready;
  logic [31:0] r0_a, r0_b, r1_a, r1_b;
  logic [3:0]  r0_aluc, r1_aluc;
  logic        resp0_valid, resp1_valid, resp0_ack, resp1_ack;
  logic [31:0] resp0_r, resp1_r;
  logic [3:0]  resp0_flags, resp1_flags;
  logic [31:0] alu_a, alu_b, alu_r;
  logic [3:0]  alu_aluc;
  logic        alu_zero, alu_carry, alu_negative, alu_overflow;

  int checks = 0;
  int errors = 0;

  logic [35:0] exp_q0[$];
  logic [35:0] exp_q1[$];
  logic [1:0]  exp_gnt  = 2'b00;
  logic [1:0]  cur_v    = 2'b00;
  logic [1:0]  mv       = 2'b00;
  int          last_m   = 1;
  int          starve_m = 0;
  logic [1:0]  prev_rdy = 2'b00;
  logic [1:0]  last_gnt = 2'b00;

  alu_arbiter #(.STARVE_MAX(STARVE)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_a(r0_a), .r0_b(r0_b), .r0_aluc(r0_aluc), .r0_ready(r0_ready),
    .resp0_valid(resp0_valid), .resp0_r(resp0_r), .resp0_flags(resp0_flags), .resp0_ack(resp0_ack),
    .r1_valid(r1_valid), .r1_a(r1_a), .r1_b(r1_b), .r1_aluc(r1_aluc), .r1_ready(r1_ready),
    .resp1_valid(resp1_valid), .resp1_r(resp1_r), .resp1_flags(resp1_flags), .resp1_ack(resp1_ack),
    .alu_a(alu_a), .alu_b(alu_b), .alu_aluc(alu_aluc), .alu_r(alu_r),
    .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_negative(alu_negative), .alu_overflow(alu_overflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural ALU: returns {r, zero, carry, negative, overflow}
  function automatic logic [35:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    logic [32:0] s;
    logic [31:0] r;
    logic        cy, ov;
    cy = 1'b0;
    ov = 1'b0;
    case (c)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd2: begin
        s  = {1'b0, a} + {1'b0, b};
        r  = s[31:0];
        cy = s[32];
        ov = (a[31] == b[31]) && (r[31] != a[31]);
      end
      4'd3: begin
        r  = a - b;
        cy = a < b;
      end
      default: r = a ^ b;
    endcase
    return {r, r == 32'd0, cy, r[31], ov};
  endfunction

  always_comb {alu_r, alu_zero, alu_carry, alu_negative, alu_overflow} = alu_fn(alu_a, alu_b, alu_aluc);

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: apply one cycle of inputs and advance the reference model for that cycle
  task automatic drive(input logic v0, input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] c0,
                       input logic k0, input logic v1, input logic [31:0] a1, input logic [31:0] b1,
                       input logic [3:0] c1, input logic k1);
    logic e0, e1;
    int   winner;
    r0_valid = v0; r0_a = a0; r0_b = b0; r0_aluc = c0; resp0_ack = k0;
    r1_valid = v1; r1_a = a1; r1_b = b1; r1_aluc = c1; resp1_ack = k1;
    cur_v = mv;
    e0 = v0 && (!mv[0] || k0);
    e1 = v1 && (!mv[1] || k1);
    winner = -1;
`ifdef ALU_ARB_FIXED_PRIO_EN
    if (e1 && (!e0 || starve_m == STARVE)) winner = 1;
    else if (e0) winner = 0;
    if (!v1 || winner == 1) starve_m = 0;
    else if (e1) starve_m = starve_m + 1;
`else
    if (e0 && e1) winner = 1 - last_m;
    else if (e0) winner = 0;
    else if (e1) winner = 1;
    if (winner >= 0) last_m = winner;
`endif
    exp_gnt = {winner == 1, winner == 0};
    if (winner == 0) exp_q0.push_back(alu_fn(a0, b0, c0));
    if (winner == 1) exp_q1.push_back(alu_fn(a1, b1, c1));
    mv[0] = (winner == 0) ? 1'b1 : (k0 ? 1'b0 : mv[0]);
    mv[1] = (winner == 1) ? 1'b1 : (k1 ? 1'b0 : mv[1]);
  endtask

  task automatic step(input logic v0, input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] c0,
                      input logic k0, input logic v1, input logic [31:0] a1, input logic [31:0] b1,
                      input logic [3:0] c1, input logic k1);
    drive(v0, a0, b0, c0, k0, v1, a1, b1, c1, k1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic k0, input logic k1);
    step(1'b0, 32'd0, 32'd0, 4'd0, k0, 1'b0, 32'd0, 32'd0, 4'd0, k1);
  endtask

  task automatic clear_model();
    exp_q0.delete();
    exp_q1.delete();
    mv = 2'b00;
    last_m = 1;
    starve_m = 0;
    drive(1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
  endtask

  // assumes rst is already high; releases it between edges
  task automatic finish_reset();
    clear_model();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_reset_valid0", resp0_valid, 1'b0);
    chk("post_reset_valid1", resp1_valid, 1'b0);
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 4))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      prev_rdy = 2'b00;
    end else begin
      chk("ready0", r0_ready, exp_gnt[0]);
      chk("ready1", r1_ready, exp_gnt[1]);
      chk("resp_valid0", resp0_valid, cur_v[0]);
      chk("resp_valid1", resp1_valid, cur_v[1]);
      if (prev_rdy[0]) begin
        if (exp_q0.size() == 0) chk("resp0_unexpected", 1'b1, 1'b0);
        else chk("resp0_data", {resp0_r, resp0_flags}, exp_q0.pop_front());
      end
      if (prev_rdy[1]) begin
        if (exp_q1.size() == 0) chk("resp1_unexpected", 1'b1, 1'b0);
        else chk("resp1_data", {resp1_r, resp1_flags}, exp_q1.pop_front());
      end
      prev_rdy = {r1_ready, r0_ready};
      last_gnt = prev_rdy;
    end
  end

  initial begin
    logic [1:0] seq [8];
    rst = 1'b1;
    r0_valid = 1'b1; r1_valid = 1'b1;
    r0_a = 32'd1; r0_b = 32'd1; r0_aluc = 4'd2; resp0_ack = 1'b0;
    r1_a = 32'd1; r1_b = 32'd1; r1_aluc = 4'd2; resp1_ack = 1'b0;
    #12;
    chk("reset_ready", {r1_ready, r0_ready}, 2'b00);
    chk("reset_valid", {resp1_valid, resp0_valid}, 2'b00);
    chk("reset_data0", {resp0_r, resp0_flags}, 36'd0);
    chk("reset_data1", {resp1_r, resp1_flags}, 36'd0);
    chk("reset_alu", {alu_a, alu_b, alu_aluc}, 68'd0);
    finish_reset();

    // single requester add: 0x7FFFFFFF + 1
    step(1'b1, 32'h7FFF_FFFF, 32'd1, 4'd2, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
    chk("single_grant", last_gnt, 2'b01);
    chk("single_valid", resp0_valid, 1'b1);
    chk("single_r", resp0_r, 32'h8000_0000);
    chk("single_flags", resp0_flags, 4'b0011);
    idle(1'b1, 1'b0);

    // contention from reset with acks held high
    rst = 1'b1;
    finish_reset();
`ifdef ALU_ARB_FIXED_PRIO_EN
    seq = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b10};
`else
    seq = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
`endif
    for (int i = 0; i < 8; i++) begin
      step(1'b1, $urandom, $urandom, 4'(i), 1'b1, 1'b1, $urandom, $urandom, 4'(i + 3), 1'b1);
      chk($sformatf("contend_grant%0d", i), last_gnt, seq[i]);
    end
    idle(1'b1, 1'b1);

    // backpressure on requester 1
    step(1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b1, 32'd9, 32'd4, 4'd3, 1'b0);
    chk("bp_fill", last_gnt, 2'b10);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b1, $urandom, $urandom, 4'd3, 1'b0);
      chk($sformatf("bp_stall%0d", i), last_gnt, 2'b00);
    end
    step(1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b1, 32'd5, 32'd7, 4'd3, 1'b1);
    chk("bp_release", last_gnt, 2'b10);
    chk("bp_valid", resp1_valid, 1'b1);
    chk("bp_r", resp1_r, 32'hFFFF_FFFE);
    chk("bp_carry", resp1_flags[2], 1'b1);
    idle(1'b1, 1'b1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, rnd_op(), rnd_op(), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 3) != 0, rnd_op(), rnd_op(), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b1);
    chk("drain_q0", exp_q0.size(), 0);
    chk("drain_q1", exp_q1.size(), 0);

    // asynchronous reset while resp0 full and requester 1 being granted
    step(1'b1, 32'd3, 32'd4, 4'd2, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
    drive(1'b1, 32'd1, 32'd1, 4'd2, 1'b0, 1'b1, 32'd6, 32'd2, 4'd3, 1'b1);
    #2;
    chk("prerst_valid0", resp0_valid, 1'b1);
    chk("prerst_ready1", r1_ready, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_async_valid", {resp1_valid, resp0_valid}, 2'b00);
    chk("rst_async_ready", {r1_ready, r0_ready}, 2'b00);
    finish_reset();
    idle(1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
